// File: rtl/src_gather.sv
// Gathers a one-word-per-beat stream into four-lane bundles and queues them in a
// small circular FIFO; short final groups are zero-padded.
module src_gather #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          src_valid,
  output logic [DW-1:0] src_data0,
  output logic [DW-1:0] src_data1,
  output logic [DW-1:0] src_data2,
  output logic [DW-1:0] src_data3,
  output logic          src_last,
  input  logic          src_ready,
  output logic [15:0]   bundles
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 4 * DW + 1;

  logic [DW-1:0] lane_reg [4];
  logic [1:0]    li_reg;
  logic [EW-1:0] mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [15:0]   bundles_reg;

  logic          push, complete, pop;
  logic [EW-1:0] bundle_next;
  logic [EW-1:0] head;

  assign in_ready  = (count_reg != CW'(DEPTH));
  assign src_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign complete  = push & ((li_reg == 2'd3) | in_last);
  assign pop       = src_valid & src_ready;

  assign bundle_next[EW-1] = in_last;

  // Bundle image including the word being accepted; lanes above li are zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        bundle_next[gi*DW +: DW] = '0;
        if (li_reg == 2'(gi))
          bundle_next[gi*DW +: DW] = in_data;
        else if (2'(gi) < li_reg)
          bundle_next[gi*DW +: DW] = lane_reg[gi];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          lane_reg[gi] <= '0;
        else if (complete)
          lane_reg[gi] <= '0;
        else if (push && li_reg == 2'(gi))
          lane_reg[gi] <= in_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      li_reg <= '0;
    else if (complete)
      li_reg <= '0;
    else if (push)
      li_reg <= li_reg + 2'd1;
  end

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      bundles_reg <= '0;
    end else begin
      if (complete) begin
        mem_reg[wr_ptr_reg] <= bundle_next;
        wr_ptr_reg          <= wr_ptr_reg + AW'(1);
        bundles_reg         <= bundles_reg + 16'd1;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (complete && !pop)
        count_reg <= count_reg + CW'(1);
      else if (pop && !complete)
        count_reg <= count_reg - CW'(1);
    end
  end

  assign head      = mem_reg[rd_ptr_reg];
  assign src_data0 = head[0*DW +: DW];
  assign src_data1 = head[1*DW +: DW];
  assign src_data2 = head[2*DW +: DW];
  assign src_data3 = head[3*DW +: DW];
  assign src_last  = head[EW-1];
  assign bundles   = bundles_reg;

endmodule

// File: tb/tb_src_gather.sv
// Directed bench for src_gather: a model of the gather logic pushes expected
// bundles into a queue, and a monitor pops/compares each bundle the DUT hands out.
module tb_src_gather;
  localparam int DW = 32;
  localparam int EW = 4 * DW + 1;

  logic          clk = 0;
  logic          rst = 0;
  logic          in_valid = 0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 0;
  logic          in_ready;
  logic          src_valid;
  logic [DW-1:0] src_data0, src_data1, src_data2, src_data3;
  logic          src_last;
  logic          src_ready = 0;
  logic [15:0]   bundles;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] m_lane [4];
  int            m_li = 0;
  logic [15:0]   m_bundles = '0;

  src_gather #(.DW(DW), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .src_valid(src_valid), .src_data0(src_data0), .src_data1(src_data1),
    .src_data2(src_data2), .src_data3(src_data3), .src_last(src_last),
    .src_ready(src_ready), .bundles(bundles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_lane[i] = '0;
    m_li = 0;
  endtask

  // Called #1 after a posedge; returns #1 after the edge that accepted the word.
  task automatic send_word(input logic [DW-1:0] d, input logic last);
    int k;
    in_valid = 1; in_data = d; in_last = last;
    k = 0;
    while (!in_ready) begin
      @(posedge clk); #1;
      k++;
      if (k > 200) begin
        chk("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    m_lane[m_li] = d;
    if (m_li == 3 || last) begin
      exp_q.push_back({last, m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
      m_bundles = m_bundles + 16'd1;
      model_clear();
    end else begin
      m_li++;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && src_valid && src_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bundle", 64'(src_data0), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        n_tests++;
        assert ({src_last, src_data3, src_data2, src_data1, src_data0} === e) else begin
          n_fail++;
          $error("FAIL bundle observed=%0h expected=%0h",
                 {src_last, src_data3, src_data2, src_data1, src_data0}, e);
        end
        $display("[TB] bundle d0=%0h d1=%0h d2=%0h d3=%0h last=%0b",
                 src_data0, src_data1, src_data2, src_data3, src_last);
      end
    end
  end

  initial begin
    logic [DW-1:0] head0;
    model_clear();
    rst = 1;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_src_valid", 64'(src_valid), 64'd0);
    chk("rst_data", 64'(src_data0 | src_data1 | src_data2 | src_data3), 64'd0);
    chk("rst_last", 64'(src_last), 64'd0);
    chk("rst_bundles", 64'(bundles), 64'd0);
    rst = 0;
    @(posedge clk); #1;

    // Basic gather
    src_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      send_word(DW'(i), i == 8);
      if (i == 3) chk("no_early_valid", 64'(src_valid), 64'd0);
      if (i == 4) chk("latency_valid", 64'(src_valid), 64'd1);
      if (i == 8) chk("latency_valid2", 64'(src_valid), 64'd1);
    end
    drain();
    chk("bundles_2", 64'(bundles), 64'd2);

    // Short tail, then next transfer starts in lane 0
    send_word(32'hA, 0);
    send_word(32'hB, 1);
    send_word(32'hC, 1);
    drain();

    // Single word
    src_ready = 0;
    send_word(32'h55, 1);
    chk("single_valid", 64'(src_valid), 64'd1);
    chk("single_d0", 64'(src_data0), 64'h55);
    chk("single_d1", 64'(src_data1), 64'h0);
    src_ready = 1;
    drain();

    // Back-pressure
    src_ready = 0;
    for (int i = 1; i <= 8; i++) send_word(DW'(32'h100 + i), 0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_d0", 64'(src_data0), 64'h101);
    head0 = src_data0;
    in_valid = 1; in_data = 32'h109; in_last = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_still_low", 64'(in_ready), 64'd0);
    chk("bp_head_stable", 64'(src_data0), 64'(head0));
    src_ready = 1;
    @(posedge clk); #1;
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    for (int i = 9; i <= 12; i++) send_word(DW'(32'h100 + i), i == 12);
    drain();

    // Reset mid-operation
    src_ready = 0;
    for (int i = 1; i <= 4; i++) send_word(DW'(32'h20 + i), 0);
    send_word(32'h31, 0);
    send_word(32'h32, 0);
    #3 rst = 1;
    #1;
    chk("mid_rst_valid", 64'(src_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_bundles", 64'(bundles), 64'd0);
    chk("mid_rst_data", 64'(src_data0 | src_data3), 64'd0);
    exp_q.delete();
    model_clear();
    m_bundles = '0;
    #2 rst = 0;
    @(posedge clk); #1;
    src_ready = 1;
    for (int i = 1; i <= 4; i++) send_word(DW'(i), 0);
    drain();
    chk("post_rst_bundles", 64'(bundles), 64'd1);

    // Counter wrap
    while (m_bundles != 16'hFFFF) send_word(DW'(m_bundles), 1);
    drain();
    chk("bundles_max", 64'(bundles), 64'hFFFF);
    send_word(32'h77, 1);
    chk("bundles_wrap", 64'(bundles), 64'd0);
    chk("wrap_d0", 64'(src_data0), 64'h77);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/src_gather.md
# src_gather

Upstream ingress stage for the accelerator top level. It accepts a one-word-per-beat input stream from the DMA and gathers consecutive words into four-lane bundles. It then presents the bundles on the `src_valid`/`src_data0..3`/`src_last`/`src_ready` interface consumed by the accelerator top (src buffer and weight/bias write path). A two-entry bundle FIFO decouples DMA bursts from top-level back-pressure. Short final groups are zero-padded.

## Interface
Parameters:
- `DW`, 32, width of one data word (lane).
- `DEPTH`, 2, bundle FIFO entries (power of two, ≥2).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_data`  in  DW  input word.
- `in_last`  in  1  final word of the transfer.
- `in_ready`  out  1  word accepted when `in_valid & in_ready`.
- `src_valid`  out  1  bundle valid (FIFO head).
- `src_data0`..`src_data3`  out  DW each  lanes 0..3; lane 0 holds the first word.
- `src_last`  out  1  bundle contains the transfer's final word.
- `src_ready`  in  1  bundle consumed when `src_valid & src_ready`.
- `bundles`  out  16  bundles pushed since reset; wraps at 65535 → 0.

## Operation
- Assembly register: four `DW` lanes plus a 2-bit lane index `li`.
  - On each accepted word, write `in_data` into lane `li`.
- Bundle completion is triggered by an accepted word with `li==3`, or with `in_last=1`.
  - Push {lanes (new word included), `in_last`} into the FIFO.
  - Unwritten lanes above `li` are pushed as 0.
  - Reset `li` to 0 and clear the assembly lanes.
  - Increment `bundles`.
- Otherwise an accepted word increments `li`.
- `in_ready = !fifo_full`. It is purely registered state, with no combinational path from `src_ready`.
- Accepting non-completing words while the FIFO is full is forbidden, so ingress stalls uniformly.
- FIFO behaviour:
  - Standard circular buffer: write pointer, read pointer, and count 0..DEPTH; pointers wrap modulo DEPTH.
  - `src_valid = (count != 0)`.
  - `src_data*` and `src_last` are the head entry, driven from registers.
  - Push and pop in the same cycle leave count unchanged. This is legal only when not full, because push needs `in_ready`.
  - Pop when empty cannot occur because `src_valid=0`.
- `src_last` is only ever set together with the bundle that contains the `in_last` word. `in_last` with `li==3` produces an unpadded bundle with `src_last=1`.
- Reset, asynchronous, possibly mid-transfer:
  - `li=0`, lanes=0, FIFO emptied, `bundles=0`.
  - Partially assembled words are discarded.
  - Outputs: `in_ready=1`, `src_valid=0`, `src_data0..3=0`, `src_last=0`, `bundles=0`.

## Timing
- Latency: the completing word accepted at edge t gives `src_valid=1` with that bundle after edge t (visible in cycle t+1). Non-completing words produce no output change.
- Throughput:
  - Ingress runs at 1 word/cycle while not full.
  - Egress runs at 1 bundle/cycle while `src_ready=1`.
  - Sustained ingress of 4 words/bundle never stalls if `src_ready` stays high.
- `in_ready` drops in the cycle after the push that makes count==DEPTH. It rises in the cycle after the first pop from full.
- `src_valid`/data hold stable while `src_valid & !src_ready`. The head is never overwritten.
- `bundles` updates at the push edge; it does not depend on egress.

## Test plan
- Basic gather: with `src_ready=1`, send words 1..8, `in_last` on 8.
  - Two bundles: {1,2,3,4,last=0} and {5,6,7,8,last=1}.
  - Each bundle is valid one cycle after its 4th word.
  - `bundles=2`.
- Short tail: send words 0xA,0xB, `in_last` on 0xB.
  - Single bundle {0xA,0xB,0,0,last=1}.
  - Next transfer word 0xC lands in lane 0.
- Single-word transfer: one word 0x55 with `in_last`.
  - Bundle {0x55,0,0,0,last=1} on the next cycle.
- Back-pressure: hold `src_ready=0`, stream 12 words.
  - `in_ready` falls after the 8th word is accepted; FIFO holds 2 bundles, and the head is stable.
  - Words 9..12 wait.
  - Raise `src_ready`: `in_ready` returns one cycle after the first pop, then 3 bundles drain in order with no loss or duplication.
- Reset mid-op: accept 2 words plus 1 full bundle queued, then pulse `rst` asynchronously between edges.
  - Outputs immediately at reset values; `bundles=0`.
  - The following words 0x1..0x4 form a clean bundle {1,2,3,4}.
- Counter wrap: preload via 65535 bundles (or force).
  - The next push gives `bundles=0` and data is unaffected.
